// File: rtl/ppu_zero_compress_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_zero_compress_pkg
//  Description : Shared constants, packet/entry types and FSM encoding for
//                the PPU zero-compression stage. Build option PPU_RELU_EN
//                clamps negative lane values to zero before compression.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_zero_compress_pkg;

    localparam int LANES      = 8;   // pooled lanes per packet
    localparam int DATA_W     = 16;  // signed activation width
    localparam int RUN_W      = 4;   // zero-run field width
    localparam int K_W        = 6;   // output-channel index width
    localparam int FIFO_DEPTH = 8;   // packet FIFO entries (power of 2)
    localparam int LIDX_W     = $clog2(LANES);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    // One pooled packet as captured from the pooling stage.
    typedef struct packed {
        logic [LANES-1:0]        valid;
        logic [LANES*DATA_W-1:0] data;
        logic [K_W-1:0]          kc;
    } ppu_lane_pkt_t;

    // One sparse (value, zero-run) entry for the output activation buffer.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RUN_W-1:0]  run;
        logic [K_W-1:0]    kc;
        logic              eoc;
    } ppu_sparse_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EOC  = 2'd2,
        ST_DONE = 2'd3
    } ppu_state_t;

    // Value as seen by the zero detector (optionally rectified).
    function automatic logic [DATA_W-1:0] lane_value(input logic [DATA_W-1:0] v);
`ifdef PPU_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

endpackage : ppu_zero_compress_pkg
`default_nettype wire

// File: rtl/ppu_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_pkt_fifo
//  Description : Synchronous FIFO of pooled lane packets with full/empty
//                flags; a push while full is accepted when a pop happens in
//                the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_pkt_fifo
    import ppu_zero_compress_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  ppu_lane_pkt_t data_i,
    input  logic          pop_i,
    output ppu_lane_pkt_t data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    ppu_lane_pkt_t mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Packet storage (no reset needed, guarded by pointers).
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule : ppu_pkt_fifo
`default_nettype wire

// File: rtl/ppu_zero_compress.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_zero_compress
//  Description : Buffers pooled lane packets and serialises them into sparse
//                (value, zero-run) entries, closing each channel with an EOC
//                entry and pulsing done after a finish. Build option
//                PPU_RELU_EN rectifies negative lanes before compression.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_zero_compress
    import ppu_zero_compress_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [K_W-1:0]          in_kc,
    input  logic                    in_finish,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [RUN_W-1:0]        out_run,
    output logic [K_W-1:0]          out_kc,
    output logic                    out_eoc,
    output logic                    done,
    output logic                    overflow
);

    ppu_state_t              state_q;
    logic [LANES-1:0]        mask_q;       // lanes of the held packet still to scan
    logic [LANES*DATA_W-1:0] lane_data_q;
    logic [K_W-1:0]          pkt_kc_q;     // kc of the held packet
    logic [K_W-1:0]          cur_kc_q;     // channel currently being emitted
    logic [RUN_W-1:0]        run_q;
    logic                    first_q;      // no packet seen since reset/done
    logic                    finish_pend_q;
    logic                    eoc_fin_q;    // current EOC was caused by finish
    logic                    done_q;
    logic                    overflow_q;
    logic                    out_valid_q;
    ppu_sparse_entry_t       out_q;

    ppu_lane_pkt_t           w_push_pkt;
    ppu_lane_pkt_t           w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push_req;
    logic                    w_push;
    logic                    w_pop;
    logic [LIDX_W-1:0]       w_idx;
    logic [DATA_W-1:0]       w_val;
    logic [LANES-1:0]        w_mask_nxt;
    logic                    w_last;
    logic                    w_advance;
    logic                    w_same_kc;

    assign w_push_pkt = '{valid: in_valid, data: in_data, kc: in_kc};
    assign w_push_req = |in_valid;
    // A full FIFO still accepts when the head leaves this same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);

    ppu_pkt_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_push_pkt),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Lane pointer = lowest pending valid lane; decide end-of-packet and pops.
    always_comb begin
        w_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i]) w_idx = LIDX_W'(i);
        end
        w_val      = lane_value(lane_data_q[int'(w_idx)*DATA_W +: DATA_W]);
        w_mask_nxt = mask_q & ~(LANES'(1) << w_idx);
        w_last     = (w_mask_nxt == '0);
        w_advance  = !out_valid_q || out_ready;
        w_same_kc  = (w_head.kc == cur_kc_q);
        w_pop      = !w_empty &&
                     ((state_q == ST_IDLE) ||
                      (state_q == ST_SCAN && w_advance && w_last && w_same_kc));
    end

    // Compression FSM with registered entry, done and overflow outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            lane_data_q   <= '0;
            pkt_kc_q      <= '0;
            cur_kc_q      <= '0;
            run_q         <= '0;
            first_q       <= 1'b1;
            finish_pend_q <= 1'b0;
            eoc_fin_q     <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_q         <= '0;
        end else begin
            done_q <= 1'b0;
            if (w_push_req && w_full && !w_pop) overflow_q <= 1'b1;
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!w_empty) begin
                        mask_q      <= w_head.valid;
                        lane_data_q <= w_head.data;
                        pkt_kc_q    <= w_head.kc;
                        if (!first_q && !w_same_kc) begin
                            eoc_fin_q <= 1'b0;
                            state_q   <= ST_EOC;
                        end else begin
                            cur_kc_q <= w_head.kc;
                            first_q  <= 1'b0;
                            state_q  <= ST_SCAN;
                        end
                    end else if (finish_pend_q) begin
                        eoc_fin_q <= 1'b1;
                        state_q   <= ST_EOC;
                    end
                end
                ST_SCAN: begin
                    if (w_advance) begin
                        if (w_val == '0) begin
                            // A zero beyond a full run becomes a padding entry.
                            if (run_q == RUN_MAX) begin
                                out_valid_q <= 1'b1;
                                out_q       <= '{data: '0, run: RUN_MAX, kc: cur_kc_q, eoc: 1'b0};
                                run_q       <= '0;
                            end else begin
                                run_q <= run_q + 1'b1;
                            end
                        end else begin
                            out_valid_q <= 1'b1;
                            out_q       <= '{data: w_val, run: run_q, kc: cur_kc_q, eoc: 1'b0};
                            run_q       <= '0;
                        end
                        if (!w_last) begin
                            mask_q <= w_mask_nxt;
                        end else if (w_pop) begin
                            mask_q      <= w_head.valid;
                            lane_data_q <= w_head.data;
                            pkt_kc_q    <= w_head.kc;
                        end else begin
                            mask_q  <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_EOC: begin
                    if (out_valid_q && out_q.eoc) begin
                        if (out_ready) begin
                            out_q.eoc <= 1'b0;
                            run_q     <= '0;
                            if (eoc_fin_q) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                cur_kc_q <= pkt_kc_q;
                                state_q  <= ST_SCAN;
                            end
                        end
                    end else if (w_advance) begin
                        out_valid_q <= 1'b1;
                        out_q       <= '{data: '0, run: run_q, kc: cur_kc_q, eoc: 1'b1};
                    end
                end
                ST_DONE: begin
                    finish_pend_q <= 1'b0;
                    cur_kc_q      <= '0;
                    first_q       <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // A new finish is never lost, even when it lands on DONE.
            if (in_finish) finish_pend_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_run   = out_q.run;
    assign out_kc    = out_q.kc;
    assign out_eoc   = out_q.eoc;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule : ppu_zero_compress
`default_nettype wire

// File: tb/tb_ppu_zero_compress.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppu_zero_compress
//  Description : Scoreboard bench for ppu_zero_compress: directed scenarios
//                plus random packet bursts against a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_zero_compress;

    localparam int LANES  = 8;
    localparam int DATA_W = 16;
    localparam int RUN_W  = 4;
    localparam int K_W    = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic [K_W-1:0]          in_kc;
    logic                    in_finish;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [RUN_W-1:0]        out_run;
    logic [K_W-1:0]          out_kc;
    logic                    out_eoc;
    logic                    done;
    logic                    overflow;

    ppu_zero_compress dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_kc     (in_kc),
        .in_finish (in_finish),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_run   (out_run),
        .out_kc    (out_kc),
        .out_eoc   (out_eoc),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Expected entries packed as {eoc, kc, run, data}.
    logic [26:0] exp_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          done_seen = 0;
    int          exp_done  = 0;
    int          m_run;
    int          m_cur;
    bit          m_first;
    bit          rdy_rand  = 1'b0;
    bit          rdy_fix   = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model (channel-stream rules) ----------------
    function automatic void push_exp(input int d, input int r, input int k, input bit e);
        logic [26:0] x;
        x = {e, 6'(k), 4'(r), 16'(d)};
        exp_q.push_back(x);
    endfunction

    function automatic void model_pkt(input logic [LANES-1:0] v,
                                      input logic [LANES*DATA_W-1:0] d,
                                      input int k);
        logic [DATA_W-1:0] val;
        if (!m_first && k != m_cur) begin
            push_exp(0, m_run, m_cur, 1'b1);
            m_run = 0;
        end
        m_cur   = k;
        m_first = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) begin
                val = d[i*DATA_W +: DATA_W];
`ifdef PPU_RELU_EN
                if ($signed(val) < 0) val = '0;
`endif
                if (val == 0) begin
                    if (m_run == 15) begin
                        push_exp(0, 15, k, 1'b0);
                        m_run = 0;
                    end else begin
                        m_run++;
                    end
                end else begin
                    push_exp(int'(val), m_run, k, 1'b0);
                    m_run = 0;
                end
            end
        end
    endfunction

    function automatic void model_finish();
        push_exp(0, m_run, m_cur, 1'b1);
        m_run   = 0;
        m_cur   = 0;
        m_first = 1'b1;
        exp_done++;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_run   = 0;
        m_cur   = 0;
        m_first = 1'b1;
    endfunction

    // ---------------- monitor: scoreboard and hold stability ----------------
    logic [26:0] held;
    bit          held_v = 1'b0;
    always @(negedge clk) begin
        logic [26:0] cur;
        logic [26:0] e;
        cur = {out_eoc, out_kc, out_run, out_data};
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) chk("hold", {out_valid, cur}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_entry", {1'b1, cur}, 28'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("entry", cur, e);
                end
            end
            held_v = out_valid && !out_ready;
            held   = cur;
            if (done) done_seen++;
        end
    end

    // out_ready driver: fixed level or random backpressure.
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [LANES-1:0] v, input logic [LANES*DATA_W-1:0] d,
                        input int k, input bit mdl);
        in_valid = v;
        in_data  = d;
        in_kc    = K_W'(k);
        if (mdl) model_pkt(v, d, k);
        step();
        in_valid = '0;
    endtask

    task automatic finish_and_wait();
        int start;
        int n;
        start     = done_seen;
        in_finish = 1'b1;
        model_finish();
        step();
        in_finish = 1'b0;
        n = 0;
        while (done_seen == start && n < 2000) begin
            step();
            n++;
        end
        chk("done_pulse", 64'(done_seen - start), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (40) step();
    endtask

    function automatic logic [DATA_W-1:0] rnd_val();
        case ($urandom_range(0, 9))
            6:       return 16'h0001;
            7:       return 16'hFFFF;
            8:       return 16'h8000;
            9:       return 16'($urandom);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [LANES*DATA_W-1:0] lanes8(input int a, input int b,
                                                       input int c, input int d, input int e);
        logic [LANES*DATA_W-1:0] r;
        r = '0;
        r[0*DATA_W +: DATA_W] = 16'(a);
        r[1*DATA_W +: DATA_W] = 16'(b);
        r[2*DATA_W +: DATA_W] = 16'(c);
        r[3*DATA_W +: DATA_W] = 16'(d);
        r[4*DATA_W +: DATA_W] = 16'(e);
        return r;
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        logic [LANES-1:0]        v;
        logic [LANES*DATA_W-1:0] d;
        int                      kb;

        rst = 1'b1; in_valid = '0; in_data = '0; in_kc = '0; in_finish = 1'b0;
        model_reset();
        step(); step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_run",   64'(out_run),   64'd0);
        chk("rst_out_kc",    64'(out_kc),    64'd0);
        chk("rst_out_eoc",   64'(out_eoc),   64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        rst = 1'b0;
        step();

        // Basic packet with latency measurement.
        send(8'hFF, lanes8(5, 0, 0, 7, 0), 0, 1'b1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'd2);
        finish_and_wait();
        wait_drain();

        // Twenty zeros then a nine: padding entry then run of four.
        send(8'hFF, '0, 1, 1'b1);
        send(8'hFF, '0, 1, 1'b1);
        send(8'h1F, lanes8(0, 0, 0, 0, 9), 1, 1'b1);
        finish_and_wait();
        wait_drain();

        // Channel change emits EOC for the previous channel.
        send(8'hFF, lanes8(1, 0, 0, 0, 0), 2, 1'b1);
        send(8'hFF, lanes8(1, 0, 0, 0, 0), 3, 1'b1);
        finish_and_wait();
        wait_drain();

        // Negative lane (rectified only with the build option).
        send(8'hFF, lanes8(-3, 0, 0, 0, 0), 4, 1'b1);
        finish_and_wait();
        wait_drain();

        // Backpressure hold and overflow on the ninth queued packet.
        rdy_fix = 1'b0;
        step();
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = 16'(i + 1);
        send(8'hFF, d, 5, 1'b1);
        repeat (4) step();
        for (int p = 0; p < 9; p++) begin
            for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = rnd_val();
            send(8'hFF, d, 5, p < 8);
            if (p == 7) chk("overflow_before_9th", 64'(overflow), 64'd0);
            if (p == 8) chk("overflow_on_9th",     64'(overflow), 64'd1);
        end
        rdy_rand = 1'b1;
        finish_and_wait();
        wait_drain();
        chk("overflow_sticky", 64'(overflow), 64'd1);

        // Random bursts with random backpressure.
        for (int b = 0; b < 15; b++) begin
            kb = $urandom_range(0, 62);
            for (int p = 0; p < $urandom_range(1, 4); p++) begin
                v = LANES'($urandom);
                if (v == '0) v = 8'h01;
                for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = rnd_val();
                send(v, d, kb + $urandom_range(0, 1), 1'b1);
                repeat ($urandom_range(0, 2)) step();
            end
            if ($urandom_range(0, 1) == 1) finish_and_wait();
            wait_drain();
        end

        // Reset in the middle of a scan.
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        step();
        for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = 16'(i + 3);
        send(8'hFF, d, 7, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        model_reset();
        step();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_overflow",  64'(overflow),  64'd0);
        chk("midrst_done",      64'(done),      64'd0);
        rst = 1'b0;
        step();
        send(8'hFF, lanes8(0, 4, 0, 0, 6), 9, 1'b1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("latency_after_rst", 64'(lat), 64'd3);
        finish_and_wait();
        wait_drain();

        chk("done_count", 64'(done_seen), 64'(exp_done));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ppu_zero_compress
`default_nettype wire
